// File: rtl/axi_gran_burst_ax_chopper.sv
// AX-channel chopper: accepts one AR/AW beat, allocates a response counter for it,
// then emits it as a series of sub-bursts of at most (len_limit_i + 1) beats.
// WRAP and the reserved burst type are forwarded whole.
// Optional build macro: AXI_GRAN_CHOP_STATS_EN adds saturating chunk/burst counters.
module axi_gran_burst_ax_chopper #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdWidth   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [7:0]           len_limit_i,
    input  logic                 ax_valid_i,
    output logic                 ax_ready_o,
    input  logic [IdWidth-1:0]   ax_id_i,
    input  logic [AddrWidth-1:0] ax_addr_i,
    input  logic [7:0]           ax_len_i,
    input  logic [2:0]           ax_size_i,
    input  logic [1:0]           ax_burst_i,
    output logic                 alloc_req_o,
    output logic [IdWidth-1:0]   alloc_id_o,
    output logic [7:0]           alloc_len_o,
    input  logic                 alloc_gnt_i,
    output logic                 oup_valid_o,
    input  logic                 oup_ready_i,
    output logic [IdWidth-1:0]   oup_id_o,
    output logic [AddrWidth-1:0] oup_addr_o,
    output logic [7:0]           oup_len_o,
    output logic [2:0]           oup_size_o,
    output logic [1:0]           oup_burst_o,
    output logic                 oup_last_o
`ifdef AXI_GRAN_CHOP_STATS_EN
    ,
    output logic [31:0]          chunk_cnt_o,
    output logic [31:0]          burst_cnt_o
`endif
);

    localparam logic [1:0] BurstIncr = 2'b01;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e                 state_q, state_d;
    logic [IdWidth-1:0]     id_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [2:0]             size_q;
    logic [1:0]             burst_q;
    logic [7:0]             limit_q;
    logic [8:0]             rem_q;   // beats still to emit (1..256)

    logic                   accept;
    logic                   oup_hs;
    logic                   fits;
    logic [8:0]             rem_m1;
    logic [8:0]             beats;
    logic [AddrWidth-1:0]   addr_inc;

    // Allocation request is passed straight through; it never looks at ax_ready_o.
    assign alloc_id_o  = ax_id_i;
    assign alloc_len_o = ax_len_i;

    assign oup_id_o    = id_q;
    assign oup_addr_o  = addr_q;
    assign oup_size_o  = size_q;
    assign oup_burst_o = burst_q;

    // Sub-burst length: FIXED/INCR (burst[1]=0) are chopped, WRAP/reserved go out whole.
    always_comb begin
        rem_m1 = rem_q - 9'd1;
        fits   = (rem_m1 <= {1'b0, limit_q});
        if (!burst_q[1]) begin
            oup_len_o  = fits ? rem_m1[7:0] : limit_q;
            oup_last_o = fits;
        end else begin
            oup_len_o  = rem_m1[7:0];
            oup_last_o = 1'b1;
        end
        beats    = {1'b0, oup_len_o} + 9'd1;
        addr_inc = AddrWidth'(beats) << size_q;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d     = state_q;
        ax_ready_o  = 1'b0;
        alloc_req_o = 1'b0;
        oup_valid_o = 1'b0;
        accept      = 1'b0;
        oup_hs      = 1'b0;
        unique case (state_q)
            StIdle: begin
                alloc_req_o = ax_valid_i;
                ax_ready_o  = alloc_gnt_i;
                accept      = ax_valid_i & alloc_gnt_i;
                if (accept) state_d = StBusy;
            end
            StBusy: begin
                oup_valid_o = 1'b1;
                oup_hs      = oup_ready_i;
                if (oup_ready_i && oup_last_o) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // Burst context: captured on acceptance, advanced on each sub-burst handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_q    <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            burst_q <= '0;
            limit_q <= '0;
            rem_q   <= '0;
        end else if (accept) begin
            id_q    <= ax_id_i;
            addr_q  <= ax_addr_i;
            size_q  <= ax_size_i;
            burst_q <= ax_burst_i;
            limit_q <= len_limit_i;
            rem_q   <= {1'b0, ax_len_i} + 9'd1;
        end else if (oup_hs) begin
            rem_q <= rem_q - beats;
            // No 4 KiB check: a legal INCR burst never crosses one.
            if (burst_q == BurstIncr) addr_q <= addr_q + addr_inc;
        end
    end

`ifdef AXI_GRAN_CHOP_STATS_EN
    // Saturating statistics counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chunk_cnt_o <= '0;
            burst_cnt_o <= '0;
        end else begin
            if (oup_hs && chunk_cnt_o != 32'hFFFF_FFFF) chunk_cnt_o <= chunk_cnt_o + 32'd1;
            if (accept && burst_cnt_o != 32'hFFFF_FFFF) burst_cnt_o <= burst_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_gran_burst_ax_chopper.sv
// Directed bench for axi_gran_burst_ax_chopper. Inputs change and outputs are
// sampled just after the falling edge; the DUT acts on the rising edge.
module tb_axi_gran_burst_ax_chopper;

    localparam int unsigned AddrWidth = 64;
    localparam int unsigned IdWidth   = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [7:0]           len_limit_i;
    logic                 ax_valid_i;
    logic                 ax_ready_o;
    logic [IdWidth-1:0]   ax_id_i;
    logic [AddrWidth-1:0] ax_addr_i;
    logic [7:0]           ax_len_i;
    logic [2:0]           ax_size_i;
    logic [1:0]           ax_burst_i;
    logic                 alloc_req_o;
    logic [IdWidth-1:0]   alloc_id_o;
    logic [7:0]           alloc_len_o;
    logic                 alloc_gnt_i;
    logic                 oup_valid_o;
    logic                 oup_ready_i;
    logic [IdWidth-1:0]   oup_id_o;
    logic [AddrWidth-1:0] oup_addr_o;
    logic [7:0]           oup_len_o;
    logic [2:0]           oup_size_o;
    logic [1:0]           oup_burst_o;
    logic                 oup_last_o;
`ifdef AXI_GRAN_CHOP_STATS_EN
    logic [31:0]          chunk_cnt_o;
    logic [31:0]          burst_cnt_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    axi_gran_burst_ax_chopper #(
        .AddrWidth (AddrWidth),
        .IdWidth   (IdWidth)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .len_limit_i (len_limit_i),
        .ax_valid_i  (ax_valid_i),
        .ax_ready_o  (ax_ready_o),
        .ax_id_i     (ax_id_i),
        .ax_addr_i   (ax_addr_i),
        .ax_len_i    (ax_len_i),
        .ax_size_i   (ax_size_i),
        .ax_burst_i  (ax_burst_i),
        .alloc_req_o (alloc_req_o),
        .alloc_id_o  (alloc_id_o),
        .alloc_len_o (alloc_len_o),
        .alloc_gnt_i (alloc_gnt_i),
        .oup_valid_o (oup_valid_o),
        .oup_ready_i (oup_ready_i),
        .oup_id_o    (oup_id_o),
        .oup_addr_o  (oup_addr_o),
        .oup_len_o   (oup_len_o),
        .oup_size_o  (oup_size_o),
        .oup_burst_o (oup_burst_o),
        .oup_last_o  (oup_last_o)
`ifdef AXI_GRAN_CHOP_STATS_EN
        ,
        .chunk_cnt_o (chunk_cnt_o),
        .burst_cnt_o (burst_cnt_o)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one AX with immediate grant; returns at the falling edge after acceptance.
    task automatic issue_ax(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [7:0] limit);
        ax_valid_i  = 1'b1;
        ax_id_i     = id;
        ax_addr_i   = addr;
        ax_len_i    = len;
        ax_size_i   = size;
        ax_burst_i  = burst;
        len_limit_i = limit;
        alloc_gnt_i = 1'b1;
        #1;
        check_eq("acc_ax_ready", ax_ready_o, 1'b1);
        check_eq("acc_alloc_req", alloc_req_o, 1'b1);
        check_eq("acc_alloc_id", alloc_id_o, id);
        check_eq("acc_alloc_len", alloc_len_o, len);
        @(negedge clk_i);
        ax_valid_i  = 1'b0;
        alloc_gnt_i = 1'b0;
    endtask

    // Accept one sub-burst with ready high and check its fields.
    task automatic take_chunk(input string tag, input logic [63:0] addr, input logic [7:0] len,
                              input logic last);
        int cyc = 0;
        oup_ready_i = 1'b1;
        #1;
        while (!oup_valid_o && cyc < 20) begin
            @(negedge clk_i);
            #1;
            cyc++;
        end
        check_eq({tag, "_valid"}, oup_valid_o, 1'b1);
        check_eq({tag, "_addr"}, oup_addr_o, addr);
        check_eq({tag, "_len"}, oup_len_o, len);
        check_eq({tag, "_last"}, oup_last_o, last);
        @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni      = 1'b0;
        len_limit_i = 8'd0;
        ax_valid_i  = 1'b0;
        ax_id_i     = '0;
        ax_addr_i   = '0;
        ax_len_i    = 8'd0;
        ax_size_i   = 3'd0;
        ax_burst_i  = 2'b00;
        alloc_gnt_i = 1'b0;
        oup_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        check_eq("rst_ax_ready", ax_ready_o, 1'b0);
        check_eq("rst_alloc_req", alloc_req_o, 1'b0);
        check_eq("rst_oup_valid", oup_valid_o, 1'b0);
`ifdef AXI_GRAN_CHOP_STATS_EN
        check_eq("rst_chunk_cnt", chunk_cnt_o, 32'd0);
        check_eq("rst_burst_cnt", burst_cnt_o, 32'd0);
`endif
        rst_ni = 1'b1;
        @(negedge clk_i);

        // INCR 0x1000 len 15 size 3 limit 3: four 4-beat chunks, 0x20 apart.
        issue_ax(4'd5, 64'h1000, 8'd15, 3'd3, 2'b01, 8'd3);
        #1;
        check_eq("t1_id", oup_id_o, 4'd5);
        check_eq("t1_size", oup_size_o, 3'd3);
        take_chunk("t1_c0", 64'h1000, 8'd3, 1'b0);
        take_chunk("t1_c1", 64'h1020, 8'd3, 1'b0);
        take_chunk("t1_c2", 64'h1040, 8'd3, 1'b0);
        take_chunk("t1_c3", 64'h1060, 8'd3, 1'b1);
        #1;
        check_eq("t1_idle", oup_valid_o, 1'b0);
        @(negedge clk_i);

        // INCR 0x2000 len 5 size 2 limit 3: 4 beats then 2 beats at 0x2010.
        issue_ax(4'd1, 64'h2000, 8'd5, 3'd2, 2'b01, 8'd3);
        take_chunk("t2_c0", 64'h2000, 8'd3, 1'b0);
        take_chunk("t2_c1", 64'h2010, 8'd1, 1'b1);

        // FIXED 0x3000 len 7 limit 1: four 2-beat chunks, address fixed.
        issue_ax(4'd2, 64'h3000, 8'd7, 3'd2, 2'b00, 8'd1);
        take_chunk("t3_c0", 64'h3000, 8'd1, 1'b0);
        take_chunk("t3_c1", 64'h3000, 8'd1, 1'b0);
        take_chunk("t3_c2", 64'h3000, 8'd1, 1'b0);
        take_chunk("t3_c3", 64'h3000, 8'd1, 1'b1);

        // WRAP len 3 limit 0: never split.
        issue_ax(4'd3, 64'h3100, 8'd3, 3'd2, 2'b10, 8'd0);
        take_chunk("t3_wrap", 64'h3100, 8'd3, 1'b1);
        // Reserved burst type behaves like WRAP.
        issue_ax(4'd3, 64'h3200, 8'd9, 3'd2, 2'b11, 8'd2);
        take_chunk("t3_rsvd", 64'h3200, 8'd9, 1'b1);
        // limit 255: single sub-burst.
        issue_ax(4'd3, 64'h3400, 8'd255, 3'd0, 2'b01, 8'd255);
        take_chunk("t3_l255", 64'h3400, 8'd255, 1'b1);

        // Grant withheld for 5 cycles.
        oup_ready_i = 1'b0;
        ax_valid_i  = 1'b1;
        ax_id_i     = 4'd7;
        ax_addr_i   = 64'h3800;
        ax_len_i    = 8'd1;
        ax_size_i   = 3'd2;
        ax_burst_i  = 2'b01;
        len_limit_i = 8'd3;
        alloc_gnt_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("t4_req", alloc_req_o, 1'b1);
            check_eq("t4_ready", ax_ready_o, 1'b0);
            check_eq("t4_novalid", oup_valid_o, 1'b0);
            @(negedge clk_i);
        end
        alloc_gnt_i = 1'b1;
        #1;
        check_eq("t4_grant_ready", ax_ready_o, 1'b1);
        @(negedge clk_i);
        ax_valid_i  = 1'b0;
        alloc_gnt_i = 1'b0;
        #1;
        check_eq("t4_valid", oup_valid_o, 1'b1);
        take_chunk("t4_c0", 64'h3800, 8'd1, 1'b1);

        // Stalled INCR len 15 size 0 limit 3; limit changed after acceptance.
        issue_ax(4'd4, 64'h4000, 8'd15, 3'd0, 2'b01, 8'd3);
        len_limit_i = 8'd0;
        for (int k = 0; k < 4; k++) begin
            int stall;
            logic [63:0] ea;
            ea    = 64'h4000 + 64'(k * 4);
            stall = int'($urandom_range(3, 1));
            oup_ready_i = 1'b0;
            for (int s = 0; s < stall; s++) begin
                #1;
                check_eq("t5_stall_valid", oup_valid_o, 1'b1);
                check_eq("t5_stall_addr", oup_addr_o, ea);
                check_eq("t5_stall_len", oup_len_o, 8'd3);
                check_eq("t5_stall_last", oup_last_o, (k == 3) ? 1'b1 : 1'b0);
                @(negedge clk_i);
            end
            take_chunk("t5_chunk", ea, 8'd3, (k == 3) ? 1'b1 : 1'b0);
        end

        // Reset after the 2nd sub-burst of a 4-chunk burst.
        issue_ax(4'd6, 64'h5000, 8'd15, 3'd3, 2'b01, 8'd3);
        take_chunk("t6_c0", 64'h5000, 8'd3, 1'b0);
        take_chunk("t6_c1", 64'h5020, 8'd3, 1'b0);
        oup_ready_i = 1'b0;
        #1;
        rst_ni = 1'b0;
        #1;
        check_eq("t6_rst_valid", oup_valid_o, 1'b0);
        check_eq("t6_rst_ready", ax_ready_o, 1'b0);
`ifdef AXI_GRAN_CHOP_STATS_EN
        check_eq("t6_rst_chunk_cnt", chunk_cnt_o, 32'd0);
        check_eq("t6_rst_burst_cnt", burst_cnt_o, 32'd0);
`endif
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1;
        check_eq("t6_post_valid", oup_valid_o, 1'b0);
        @(negedge clk_i);
        issue_ax(4'd8, 64'h6000, 8'd15, 3'd3, 2'b01, 8'd3);
        take_chunk("t6_n0", 64'h6000, 8'd3, 1'b0);
        take_chunk("t6_n1", 64'h6020, 8'd3, 1'b0);
        take_chunk("t6_n2", 64'h6040, 8'd3, 1'b0);
        take_chunk("t6_n3", 64'h6060, 8'd3, 1'b1);
`ifdef AXI_GRAN_CHOP_STATS_EN
        #1;
        check_eq("t6_chunk_cnt", chunk_cnt_o, 32'd4);
        check_eq("t6_burst_cnt", burst_cnt_o, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
